// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_stage
// Purpose  : Decode-stage immediate generator with a 2-entry output buffer.
//            Forms the XLEN-wide immediate and pc + imm from the incoming
//            instruction, then queues {instr, pc, imm, target, bad_src} so
//            decoder and execute are decoupled at full throughput.
// Ports    : clk, rst (async, active-high), flush (sync buffer clear)
//            in_valid/in_ready, in_instr[31:0], in_pc[XLEN-1:0],
//            in_imm_src[2:0]
//            out_valid/out_ready, out_instr[31:0], out_pc, out_imm,
//            out_target (all XLEN wide), out_bad_src
// Params   : XLEN - datapath width, 32 or 64 only
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_bad_src
);

  // Instruction-type encoding of in_imm_src; 3'd7 is undefined.
  localparam logic [2:0] c_i_type = 3'd0;
  localparam logic [2:0] c_u_type = 3'd1;
  localparam logic [2:0] c_j_type = 3'd2;
  localparam logic [2:0] c_s_type = 3'd3;
  localparam logic [2:0] c_b_type = 3'd4;
  localparam logic [2:0] c_z_type = 3'd5;
  localparam logic [2:0] c_r_type = 3'd6;

  localparam logic [6:0] c_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_imm32 = 7'b0011011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            bad;
  } entry_t;

  // --------------------------------------------------------------------------
  // Immediate formation
  // --------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_shift_f3;
  logic [31:0]     w_imm32;
  logic            w_zext;
  logic            w_bad;
  logic [XLEN-1:0] w_imm;
  entry_t          w_new;

  assign w_opcode   = in_instr[6:0];
  assign w_funct3   = in_instr[14:12];
  assign w_shift_f3 = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  always_comb begin
    w_imm32 = 32'd0;
    w_zext  = 1'b0;
    w_bad   = 1'b0;
    case (in_imm_src)
      c_i_type: begin
        // Shift immediates take only the shamt field so funct6/funct7 bits
        // (e.g. the SRAI bit 30) never reach the immediate.
        if (w_shift_f3 && (w_opcode == c_op_imm)) begin
          w_zext = 1'b1;
          if (XLEN == 64) w_imm32 = {26'd0, in_instr[25:20]};
          else            w_imm32 = {27'd0, in_instr[24:20]};
        end else if (w_shift_f3 && (w_opcode == c_op_imm32) && (XLEN == 64)) begin
          w_zext  = 1'b1;
          w_imm32 = {27'd0, in_instr[24:20]};
        end else begin
          w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      c_u_type: w_imm32 = {in_instr[31:12], 12'd0};
      c_j_type: w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
      c_s_type: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      c_b_type: w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
      c_z_type: begin
        w_zext  = 1'b1;
        w_imm32 = {27'd0, in_instr[19:15]};
      end
      c_r_type: w_zext = 1'b1;
      default: begin
        w_zext = 1'b1;
        w_bad  = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; written as fill-then-overlay so it is valid for XLEN=32.
  always_comb begin
    w_imm       = w_zext ? '0 : {XLEN{w_imm32[31]}};
    w_imm[31:0] = w_imm32;
  end

  // Target is added before buffering so the outputs carry no adder delay.
  always_comb begin
    w_new.instr  = in_instr;
    w_new.pc     = in_pc;
    w_new.imm    = w_imm;
    w_new.target = in_pc + w_imm;
    w_new.bad    = w_bad;
  end

  // --------------------------------------------------------------------------
  // 2-entry buffer: head_q always holds the oldest entry and drives the
  // outputs directly; tail_q holds the second entry when cnt_q == 2.
  // --------------------------------------------------------------------------
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       w_push, w_pop;

  assign w_push = in_valid & in_ready_q;
  assign w_pop  = out_valid_q & out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = w_new;
          else               tail_d = w_new;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        // Push and pop together can only happen at cnt 1 (push needs cnt<2,
        // pop needs cnt>0), so the new entry replaces the head.
        2'b11: head_d = w_new;
        default: ;
      endcase
    end
    // Handshake flags are precomputed so both are plain flop outputs.
    in_ready_d  = (cnt_d != 2'd2);
    out_valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = head_q.instr;
  assign out_pc      = head_q.pc;
  assign out_imm     = head_q.imm;
  assign out_target  = head_q.target;
  assign out_bad_src = head_q.bad;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_stage
// Purpose  : Directed self-checking bench for imm_gen_stage. One instance at
//            XLEN=32 and one at XLEN=64 share all inputs (the 32-bit one
//            sees the low half of the PC), so handshakes run in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

  localparam logic [2:0] I_T = 3'd0, U_T = 3'd1, J_T = 3'd2, S_T = 3'd3;
  localparam logic [2:0] B_T = 3'd4, Z_T = 3'd5, R_T = 3'd6, BAD_T = 3'd7;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [2:0]  in_imm_src;

  logic        rdy32, vld32, bad32;
  logic [31:0] instr32, pc32, imm32, tgt32;
  logic        rdy64, vld64, bad64;
  logic [31:0] instr64;
  logic [63:0] pc64, imm64, tgt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .in_imm_src(in_imm_src),
    .out_valid(vld32), .out_ready(out_ready), .out_instr(instr32),
    .out_pc(pc32), .out_imm(imm32), .out_target(tgt32), .out_bad_src(bad32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_pc(in_pc), .in_imm_src(in_imm_src),
    .out_valid(vld64), .out_ready(out_ready), .out_instr(instr64),
    .out_pc(pc64), .out_imm(imm64), .out_target(tgt64), .out_bad_src(bad64)
  );

  // Inputs change 1 time unit after the rising edge; checks sample there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [2:0] src,
                       input logic [63:0] pc);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    in_pc      = pc;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %b/%b exp 0/0", vld32, vld64); end
    checks++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got %b/%b exp 1/1", rdy32, rdy64); end
    checks++; if ({instr32, pc32, imm32, tgt32, bad32} !== '0 ||
                  {instr64, pc64, imm64, tgt64, bad64} !== '0) begin errors++;
      $display("FAIL reset_data got %h %h %h exp 0", instr32, imm32, imm64); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_itype();
    out_ready = 1'b1;
    offer(32'hFFF00093, I_T, 64'h8000_0000);
    #1;
    checks++; if (vld32 !== 1'b0) begin errors++;
      $display("FAIL no_bypass got out_valid %b exp 0", vld32); end
    step(); in_valid = 1'b0;
    checks++; if (vld32 !== 1'b1) begin errors++;
      $display("FAIL itype_latency got out_valid %b exp 1", vld32); end
    checks++; if (imm32 !== 32'hFFFF_FFFF || tgt32 !== 32'h7FFF_FFFF) begin errors++;
      $display("FAIL itype32 got imm %h tgt %h exp ffffffff 7fffffff", imm32, tgt32); end
    checks++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF || tgt64 !== 64'h7FFF_FFFF) begin errors++;
      $display("FAIL itype64 got imm %h tgt %h exp all-ones 7fffffff", imm64, tgt64); end
    step();
  endtask

  task automatic test_shift();
    offer(32'h4030D093, I_T, 64'h0);   // SRAI x1,x1,3
    step(); in_valid = 1'b0;
    checks++; if (imm32 !== 32'd3 || imm64 !== 64'd3) begin errors++;
      $display("FAIL srai3 got %h/%h exp 3/3", imm32, imm64); end
    step();
    offer(32'h4210D093, I_T, 64'h0);   // SRAI x1,x1,33
    step(); in_valid = 1'b0;
    checks++; if (imm64 !== 64'h21 || imm32 !== 32'h1) begin errors++;
      $display("FAIL srai33 got %h/%h exp 21/1", imm64, imm32); end
    step();
    offer(32'h4210D09B, I_T, 64'h0);   // OP-IMM-32 funct3 101: shamt is [24:20]
    step(); in_valid = 1'b0;
    checks++; if (imm64 !== 64'h1 || imm32 !== 32'h421) begin errors++;
      $display("FAIL sraiw got %h/%h exp 1/421", imm64, imm32); end
    step();
  endtask

  task automatic test_utype_z();
    offer(32'h800000B7, U_T, 64'h0);   // LUI
    step(); in_valid = 1'b0;
    checks++; if (imm64 !== 64'hFFFF_FFFF_8000_0000 || imm32 !== 32'h8000_0000) begin errors++;
      $display("FAIL lui got %h/%h exp ffffffff80000000/80000000", imm64, imm32); end
    step();
    offer(32'h000FD0F3, Z_T, 64'h0);   // CSRRWI x1,0,31
    step(); in_valid = 1'b0;
    checks++; if (imm64 !== 64'h1F || imm32 !== 32'h1F) begin errors++;
      $display("FAIL zimm got %h/%h exp 1f/1f", imm64, imm32); end
    step();
  endtask

  task automatic test_jsbr();
    offer(32'hFFDFF06F, J_T, 64'h8000_0010);
    step(); in_valid = 1'b0;
    checks++; if (imm32 !== 32'hFFFF_FFFC || tgt32 !== 32'h8000_000C) begin errors++;
      $display("FAIL jal32 got imm %h tgt %h exp fffffffc 8000000c", imm32, tgt32); end
    checks++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFC || tgt64 !== 64'h8000_000C) begin errors++;
      $display("FAIL jal64 got imm %h tgt %h exp -4 8000000c", imm64, tgt64); end
    step();
    offer(32'hFE20AC23, S_T, 64'h0);   // SW x2,-8(x1)
    step(); in_valid = 1'b0;
    checks++; if (imm32 !== 32'hFFFF_FFF8 || imm64 !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++;
      $display("FAIL stype got %h/%h exp -8", imm32, imm64); end
    step();
    offer(32'h00000863, B_T, 64'h1000); // BEQ x0,x0,+16
    step(); in_valid = 1'b0;
    checks++; if (imm32 !== 32'h10 || tgt32 !== 32'h1010) begin errors++;
      $display("FAIL btype got imm %h tgt %h exp 10 1010", imm32, tgt32); end
    step();
    offer(32'hFFFFFFFF, R_T, 64'h1234);
    step(); in_valid = 1'b0;
    checks++; if (imm64 !== 64'h0 || tgt64 !== 64'h1234 || pc64 !== 64'h1234) begin errors++;
      $display("FAIL rtype got imm %h tgt %h exp 0 1234", imm64, tgt64); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(32'hA0000013, I_T, 64'h100);            // A
    step();
    offer(32'hB0000013, I_T, 64'h104);            // B
    checks++; if (rdy32 !== 1'b1) begin errors++;
      $display("FAIL bp_ready_cnt1 got %b exp 1", rdy32); end
    step();
    offer(32'hC0000013, I_T, 64'h108);            // C, must be held off
    checks++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin errors++;
      $display("FAIL bp_ready_full got %b/%b exp 0/0", rdy32, rdy64); end
    step();
    checks++; if (vld32 !== 1'b1 || instr32 !== 32'hA0000013 || pc32 !== 32'h100) begin errors++;
      $display("FAIL bp_hold_a got %b %h exp 1 a0000013", vld32, instr32); end
    out_ready = 1'b1;
    step();
    checks++; if (vld32 !== 1'b1 || instr32 !== 32'hB0000013 || rdy32 !== 1'b1) begin errors++;
      $display("FAIL bp_out_b got %b %h rdy %b exp 1 b0000013 1", vld32, instr32, rdy32); end
    step(); in_valid = 1'b0;
    checks++; if (vld32 !== 1'b1 || instr32 !== 32'hC0000013 || pc32 !== 32'h108) begin errors++;
      $display("FAIL bp_out_c got %b %h exp 1 c0000013", vld32, instr32); end
    step();
    checks++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin errors++;
      $display("FAIL bp_drain got valid %b rdy %b exp 0 1", vld32, rdy32); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(32'h11100093, I_T, 64'h200); step();
    offer(32'h22200093, I_T, 64'h204); step();
    offer(32'hDDD00093, I_T, 64'h208); flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    checks++; if (vld32 !== 1'b0 || rdy32 !== 1'b1 || vld64 !== 1'b0) begin errors++;
      $display("FAIL flush_full got valid %b rdy %b exp 0 1", vld32, rdy32); end
    // Flush at cnt 1 while the offered entry is accepted-eligible.
    offer(32'h33300093, I_T, 64'h300); step();
    offer(32'hEEE00093, I_T, 64'h304); flush = 1'b1;
    checks++; if (rdy32 !== 1'b1) begin errors++;
      $display("FAIL flush_pre_ready got %b exp 1", rdy32); end
    step(); flush = 1'b0; in_valid = 1'b0;
    checks++; if (vld32 !== 1'b0) begin errors++;
      $display("FAIL flush_cnt1 got valid %b exp 0", vld32); end
    out_ready = 1'b1;
    step();
    checks++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin errors++;
      $display("FAIL flush_discard got valid %b instr %h exp 0", vld32, instr32); end
  endtask

  task automatic test_reset_bad_src();
    out_ready = 1'b0;
    offer(32'h00500093, I_T, 64'h400); step();
    offer(32'h00600093, I_T, 64'h404); step();
    in_valid = 1'b0;
    checks++; if (vld32 !== 1'b1 || rdy32 !== 1'b0) begin errors++;
      $display("FAIL rst_prefill got valid %b rdy %b exp 1 0", vld32, rdy32); end
    #2 rst = 1'b1;                   // well away from any clock edge
    #1;
    checks++; if (vld32 !== 1'b0 || vld64 !== 1'b0 || rdy32 !== 1'b1) begin errors++;
      $display("FAIL rst_async got valid %b/%b rdy %b exp 0/0 1", vld32, vld64, rdy32); end
    checks++; if ({instr32, pc32, imm32, tgt32, bad32} !== '0 ||
                  {instr64, pc64, imm64, tgt64, bad64} !== '0) begin errors++;
      $display("FAIL rst_async_data got %h %h %h exp 0", instr32, pc32, imm32); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    offer(32'hFFF00093, BAD_T, 64'h500);
    step(); in_valid = 1'b0;
    checks++; if (bad32 !== 1'b1 || imm32 !== 32'h0 || tgt32 !== 32'h500) begin errors++;
      $display("FAIL bad_src32 got bad %b imm %h tgt %h exp 1 0 500", bad32, imm32, tgt32); end
    checks++; if (bad64 !== 1'b1 || imm64 !== 64'h0) begin errors++;
      $display("FAIL bad_src64 got bad %b imm %h exp 1 0", bad64, imm64); end
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_instr   = '0;
    in_pc      = '0;
    in_imm_src = '0;
    test_reset();
    test_itype();
    test_shift();
    test_utype_z();
    test_jsbr();
    test_backpressure();
    test_flush();
    test_reset_bad_src();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
